// File: rtl/radio_bridge_mc_pkg.sv
// Shared encodings for the multi-radio bridge: sequencer states, gain field widths
// and the per-channel request decode.
package radio_bridge_mc_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRx   = 2'd1,
      StTx   = 2'd2,
      StGap  = 2'd3
   } state_e;

   localparam int unsigned GainRfW = 2;
   localparam int unsigned GainBbW = 5;
   localparam int unsigned GainTxW = 6;
   localparam int unsigned GainBW  = 7;

   // Conflicting or absent requests both mean "no mode"; StIdle stands for NONE.
   function automatic state_e decode_req(input logic rx_en, input logic tx_en);
      if (rx_en && !tx_en) begin
         return StRx;
      end else if (tx_en && !rx_en) begin
         return StTx;
      end
      return StIdle;
   endfunction

endpackage

// File: rtl/radio_bridge_mc_if.sv
// Bus bundle between radio controllers / user PHY (master) and the bridge (slave).
// Multi-channel fields are concatenated with channel 0 in the most-significant slot.
interface radio_bridge_mc_if
   import radio_bridge_mc_pkg::*;
#(
   parameter int unsigned NUM_RADIOS = 2,
   parameter int unsigned DAC_WIDTH  = 16,
   parameter int unsigned ADC_WIDTH  = 14,
   parameter int unsigned RSSI_WIDTH = 10
);

   logic [NUM_RADIOS-1:0]            controller_RxEn;
   logic [NUM_RADIOS-1:0]            controller_TxEn;
   logic [NUM_RADIOS*DAC_WIDTH-1:0]  user_DAC_I;
   logic [NUM_RADIOS*DAC_WIDTH-1:0]  user_DAC_Q;
   logic [NUM_RADIOS*DAC_WIDTH-1:0]  radio_DAC_I;
   logic [NUM_RADIOS*DAC_WIDTH-1:0]  radio_DAC_Q;
   logic [NUM_RADIOS*ADC_WIDTH-1:0]  radio_ADC_I;
   logic [NUM_RADIOS*ADC_WIDTH-1:0]  radio_ADC_Q;
   logic [NUM_RADIOS*ADC_WIDTH-1:0]  user_ADC_I;
   logic [NUM_RADIOS*ADC_WIDTH-1:0]  user_ADC_Q;
   logic [NUM_RADIOS-1:0]            user_ADC_valid;
   logic [NUM_RADIOS*GainTxW-1:0]    user_Tx_gain;
   logic [NUM_RADIOS*GainRfW-1:0]    user_RxRF_gain;
   logic [NUM_RADIOS*GainBbW-1:0]    user_RxBB_gain;
   logic [NUM_RADIOS*GainBW-1:0]     radio_B;
   logic [NUM_RADIOS-1:0]            radio_RxEn;
   logic [NUM_RADIOS-1:0]            radio_TxEn;
   logic [NUM_RADIOS-1:0]            user_TxReady;
   logic                             user_RSSI_ADC_clk;
   logic [NUM_RADIOS*RSSI_WIDTH-1:0] radio_RSSI_ADC_D;
   logic [NUM_RADIOS*RSSI_WIDTH-1:0] user_RSSI_avg;
   logic [NUM_RADIOS-1:0]            user_RSSI_valid;

   modport master (
      output controller_RxEn, controller_TxEn, user_DAC_I, user_DAC_Q, radio_ADC_I,
             radio_ADC_Q, user_Tx_gain, user_RxRF_gain, user_RxBB_gain, user_RSSI_ADC_clk,
             radio_RSSI_ADC_D,
      input  radio_DAC_I, radio_DAC_Q, user_ADC_I, user_ADC_Q, user_ADC_valid, radio_B,
             radio_RxEn, radio_TxEn, user_TxReady, user_RSSI_avg, user_RSSI_valid
   );

   modport slave (
      input  controller_RxEn, controller_TxEn, user_DAC_I, user_DAC_Q, radio_ADC_I,
             radio_ADC_Q, user_Tx_gain, user_RxRF_gain, user_RxBB_gain, user_RSSI_ADC_clk,
             radio_RSSI_ADC_D,
      output radio_DAC_I, radio_DAC_Q, user_ADC_I, user_ADC_Q, user_ADC_valid, radio_B,
             radio_RxEn, radio_TxEn, user_TxReady, user_RSSI_avg, user_RSSI_valid
   );

endinterface

// File: rtl/radio_bridge_mc_chan.sv
// One radio channel: Tx/Rx sequencer with turnaround gap, gated I/Q paths,
// gain-bus mux and boxcar RSSI averager. All outputs are registered.
module radio_bridge_mc_chan
   import radio_bridge_mc_pkg::*;
#(
   parameter int unsigned DAC_WIDTH         = 16,
   parameter int unsigned ADC_WIDTH         = 14,
   parameter int unsigned RSSI_WIDTH        = 10,
   parameter int unsigned TURNAROUND_CYCLES = 8,
   parameter int unsigned RSSI_AVG_LOG2     = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  rx_en_i,
   input  logic                  tx_en_i,
   input  logic [DAC_WIDTH-1:0]  user_dac_i_i,
   input  logic [DAC_WIDTH-1:0]  user_dac_q_i,
   output logic [DAC_WIDTH-1:0]  radio_dac_i_o,
   output logic [DAC_WIDTH-1:0]  radio_dac_q_o,
   input  logic [ADC_WIDTH-1:0]  radio_adc_i_i,
   input  logic [ADC_WIDTH-1:0]  radio_adc_q_i,
   output logic [ADC_WIDTH-1:0]  user_adc_i_o,
   output logic [ADC_WIDTH-1:0]  user_adc_q_o,
   output logic                  user_adc_valid_o,
   input  logic [GainTxW-1:0]    tx_gain_i,
   input  logic [GainRfW-1:0]    rx_rf_gain_i,
   input  logic [GainBbW-1:0]    rx_bb_gain_i,
   output logic [GainBW-1:0]     radio_b_o,
   output logic                  radio_rx_en_o,
   output logic                  radio_tx_en_o,
   output logic                  tx_ready_o,
   input  logic                  rssi_edge_i,
   input  logic [RSSI_WIDTH-1:0] rssi_d_i,
   output logic [RSSI_WIDTH-1:0] rssi_avg_o,
   output logic                  rssi_valid_o
);

   localparam int unsigned GapW = (TURNAROUND_CYCLES > 1) ? $clog2(TURNAROUND_CYCLES) : 1;
   localparam logic [GapW-1:0] GapLoad = GapW'(TURNAROUND_CYCLES - 1);
   localparam int unsigned AccW = RSSI_WIDTH + RSSI_AVG_LOG2;
   localparam int unsigned CntW = (RSSI_AVG_LOG2 > 0) ? RSSI_AVG_LOG2 : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'((1 << RSSI_AVG_LOG2) - 1);

   state_e                req;
   state_e                state_q;
   logic [GapW-1:0]       gap_cnt_q;
   logic [ADC_WIDTH-1:0]  adc_i_q, adc_q_q;
   logic [DAC_WIDTH-1:0]  dac_i_q, dac_q_q;
   logic [ADC_WIDTH-1:0]  adc_out_i_q, adc_out_q_q;
   logic                  adc_valid_q;
   logic [GainBW-1:0]     gain_q;
   logic                  rx_en_q, tx_en_q;
   logic [AccW-1:0]       acc_q, acc_sum;
   logic [CntW-1:0]       rssi_cnt_q;
   logic [RSSI_WIDTH-1:0] rssi_avg_q;
   logic                  rssi_valid_q;

   assign req = decode_req(rx_en_i, tx_en_i);

   // Sequencer and the datapath registers keyed off the current state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         gap_cnt_q   <= '0;
         adc_i_q     <= '0;
         adc_q_q     <= '0;
         dac_i_q     <= '0;
         dac_q_q     <= '0;
         adc_out_i_q <= '0;
         adc_out_q_q <= '0;
         adc_valid_q <= 1'b0;
         gain_q      <= '0;
         rx_en_q     <= 1'b0;
         tx_en_q     <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: state_q <= req;
            StRx, StTx: begin
               if (req != state_q) begin
                  state_q   <= StGap;
                  gap_cnt_q <= GapLoad;
               end
            end
            StGap: begin
               // Gap length is fixed once entered; only the final cycle's request matters.
               if (gap_cnt_q == '0) begin
                  state_q <= req;
               end else begin
                  gap_cnt_q <= gap_cnt_q - GapW'(1);
               end
            end
            default: state_q <= StIdle;
         endcase

         rx_en_q     <= (state_q == StRx);
         tx_en_q     <= (state_q == StTx);
         dac_i_q     <= (state_q == StTx) ? user_dac_i_i : '0;
         dac_q_q     <= (state_q == StTx) ? user_dac_q_i : '0;
         adc_i_q     <= radio_adc_i_i;
         adc_q_q     <= radio_adc_q_i;
         adc_out_i_q <= (state_q == StRx) ? adc_i_q : '0;
         adc_out_q_q <= (state_q == StRx) ? adc_q_q : '0;
         adc_valid_q <= (state_q == StRx);
         unique case (state_q)
            StRx:    gain_q <= {rx_rf_gain_i, rx_bb_gain_i};
            StTx:    gain_q <= {1'b0, tx_gain_i};
            default: gain_q <= '0;
         endcase
      end
   end

   assign acc_sum = acc_q + AccW'(rssi_d_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_q        <= '0;
         rssi_cnt_q   <= '0;
         rssi_avg_q   <= '0;
         rssi_valid_q <= 1'b0;
      end else begin
         rssi_valid_q <= 1'b0;
         if (rssi_edge_i) begin
            if (rssi_cnt_q == LastCnt) begin
               // Upper RSSI_WIDTH bits of the full sum are the truncated mean.
               rssi_avg_q   <= acc_sum[AccW-1 -: RSSI_WIDTH];
               rssi_valid_q <= 1'b1;
               acc_q        <= '0;
               rssi_cnt_q   <= '0;
            end else begin
               acc_q      <= acc_sum;
               rssi_cnt_q <= rssi_cnt_q + CntW'(1);
            end
         end
      end
   end

   assign radio_dac_i_o    = dac_i_q;
   assign radio_dac_q_o    = dac_q_q;
   assign user_adc_i_o     = adc_out_i_q;
   assign user_adc_q_o     = adc_out_q_q;
   assign user_adc_valid_o = adc_valid_q;
   assign radio_b_o        = gain_q;
   assign radio_rx_en_o    = rx_en_q;
   assign radio_tx_en_o    = tx_en_q;
   assign tx_ready_o       = tx_en_q;
   assign rssi_avg_o       = rssi_avg_q;
   assign rssi_valid_o     = rssi_valid_q;

endmodule

// File: rtl/radio_bridge_mc.sv
// Multi-radio bridge top: shared RSSI strobe edge detector plus NUM_RADIOS
// independent channels, each wired to its slice of the concatenated buses.
module radio_bridge_mc
   import radio_bridge_mc_pkg::*;
#(
   parameter int unsigned NUM_RADIOS        = 2,
   parameter int unsigned DAC_WIDTH         = 16,
   parameter int unsigned ADC_WIDTH         = 14,
   parameter int unsigned RSSI_WIDTH        = 10,
   parameter int unsigned TURNAROUND_CYCLES = 8,
   parameter int unsigned RSSI_AVG_LOG2     = 2
) (
   input  logic             converter_clock_in,
   input  logic             converter_reset_n,
   radio_bridge_mc_if.slave bus
);

   logic rssi_strobe_q;
   logic rssi_edge;

   logic [NUM_RADIOS*DAC_WIDTH-1:0]  dac_i, dac_q;
   logic [NUM_RADIOS*ADC_WIDTH-1:0]  adc_i, adc_q;
   logic [NUM_RADIOS-1:0]            adc_valid, rx_en, tx_en, tx_ready, rssi_valid;
   logic [NUM_RADIOS*GainBW-1:0]     gain_b;
   logic [NUM_RADIOS*RSSI_WIDTH-1:0] rssi_avg;

   always_ff @(posedge converter_clock_in or negedge converter_reset_n) begin
      if (!converter_reset_n) begin
         rssi_strobe_q <= 1'b0;
      end else begin
         rssi_strobe_q <= bus.user_RSSI_ADC_clk;
      end
   end

   assign rssi_edge = bus.user_RSSI_ADC_clk & ~rssi_strobe_q;

   for (genvar c = 0; c < NUM_RADIOS; c++) begin : g_chan
      // Channel 0 occupies the most-significant field of every bus.
      localparam int unsigned Field = NUM_RADIOS - 1 - c;

      radio_bridge_mc_chan #(
         .DAC_WIDTH         (DAC_WIDTH),
         .ADC_WIDTH         (ADC_WIDTH),
         .RSSI_WIDTH        (RSSI_WIDTH),
         .TURNAROUND_CYCLES (TURNAROUND_CYCLES),
         .RSSI_AVG_LOG2     (RSSI_AVG_LOG2)
      ) u_chan (
         .clk_i            (converter_clock_in),
         .rst_ni           (converter_reset_n),
         .rx_en_i          (bus.controller_RxEn[Field]),
         .tx_en_i          (bus.controller_TxEn[Field]),
         .user_dac_i_i     (bus.user_DAC_I[Field*DAC_WIDTH +: DAC_WIDTH]),
         .user_dac_q_i     (bus.user_DAC_Q[Field*DAC_WIDTH +: DAC_WIDTH]),
         .radio_dac_i_o    (dac_i[Field*DAC_WIDTH +: DAC_WIDTH]),
         .radio_dac_q_o    (dac_q[Field*DAC_WIDTH +: DAC_WIDTH]),
         .radio_adc_i_i    (bus.radio_ADC_I[Field*ADC_WIDTH +: ADC_WIDTH]),
         .radio_adc_q_i    (bus.radio_ADC_Q[Field*ADC_WIDTH +: ADC_WIDTH]),
         .user_adc_i_o     (adc_i[Field*ADC_WIDTH +: ADC_WIDTH]),
         .user_adc_q_o     (adc_q[Field*ADC_WIDTH +: ADC_WIDTH]),
         .user_adc_valid_o (adc_valid[Field]),
         .tx_gain_i        (bus.user_Tx_gain[Field*GainTxW +: GainTxW]),
         .rx_rf_gain_i     (bus.user_RxRF_gain[Field*GainRfW +: GainRfW]),
         .rx_bb_gain_i     (bus.user_RxBB_gain[Field*GainBbW +: GainBbW]),
         .radio_b_o        (gain_b[Field*GainBW +: GainBW]),
         .radio_rx_en_o    (rx_en[Field]),
         .radio_tx_en_o    (tx_en[Field]),
         .tx_ready_o       (tx_ready[Field]),
         .rssi_edge_i      (rssi_edge),
         .rssi_d_i         (bus.radio_RSSI_ADC_D[Field*RSSI_WIDTH +: RSSI_WIDTH]),
         .rssi_avg_o       (rssi_avg[Field*RSSI_WIDTH +: RSSI_WIDTH]),
         .rssi_valid_o     (rssi_valid[Field])
      );
   end

   assign bus.radio_DAC_I     = dac_i;
   assign bus.radio_DAC_Q     = dac_q;
   assign bus.user_ADC_I      = adc_i;
   assign bus.user_ADC_Q      = adc_q;
   assign bus.user_ADC_valid  = adc_valid;
   assign bus.radio_B         = gain_b;
   assign bus.radio_RxEn      = rx_en;
   assign bus.radio_TxEn      = tx_en;
   assign bus.user_TxReady    = tx_ready;
   assign bus.user_RSSI_avg   = rssi_avg;
   assign bus.user_RSSI_valid = rssi_valid;

endmodule

// File: tb/tb_radio_bridge_mc.sv
// Self-checking bench for radio_bridge_mc: directed scenarios plus randomized traffic
// compared cycle by cycle against a mode/gap-counter reference model.
module tb_radio_bridge_mc;

   localparam int unsigned NR   = 2;
   localparam int unsigned DW   = 16;
   localparam int unsigned AW   = 14;
   localparam int unsigned RW   = 10;
   localparam int unsigned TURN = 8;
   localparam int unsigned AVGL = 2;
   localparam int unsigned AllW = NR * (2*DW + 2*AW + RW + 12);
   localparam int unsigned C0   = NR - 1;  // bit/field index of channel 0

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   radio_bridge_mc_if #(.NUM_RADIOS(NR), .DAC_WIDTH(DW), .ADC_WIDTH(AW), .RSSI_WIDTH(RW)) bus ();

   radio_bridge_mc #(
      .NUM_RADIOS(NR), .DAC_WIDTH(DW), .ADC_WIDTH(AW), .RSSI_WIDTH(RW),
      .TURNAROUND_CYCLES(TURN), .RSSI_AVG_LOG2(AVGL)
   ) dut (
      .converter_clock_in (clk),
      .converter_reset_n  (rst_n),
      .bus                (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: mode 0=none 1=rx 2=tx, gap = cycles of turnaround still to serve.
   int m_mode[NR];
   int m_gap[NR];
   int m_sum[NR];
   int m_n[NR];
   logic m_strobe;
   logic [NR*AW-1:0] m_adc_i, m_adc_q;
   logic [NR*DW-1:0] e_dac_i, e_dac_q;
   logic [NR*AW-1:0] e_adc_i, e_adc_q;
   logic [NR-1:0]    e_adc_valid, e_rx, e_tx, e_rdy, e_rssi_valid;
   logic [NR*7-1:0]  e_b;
   logic [NR*RW-1:0] e_avg;

   wire [AllW-1:0] obs_all = {bus.radio_DAC_I, bus.radio_DAC_Q, bus.user_ADC_I, bus.user_ADC_Q,
                              bus.user_ADC_valid, bus.radio_B, bus.radio_RxEn, bus.radio_TxEn,
                              bus.user_TxReady, bus.user_RSSI_avg, bus.user_RSSI_valid};
   wire [AllW-1:0] exp_all = {e_dac_i, e_dac_q, e_adc_i, e_adc_q, e_adc_valid, e_b, e_rx, e_tx,
                              e_rdy, e_avg, e_rssi_valid};

   task automatic model_reset();
      for (int c = 0; c < NR; c++) begin
         m_mode[c] = 0; m_gap[c] = 0; m_sum[c] = 0; m_n[c] = 0;
      end
      m_strobe = 1'b0; m_adc_i = '0; m_adc_q = '0;
      e_dac_i = '0; e_dac_q = '0; e_adc_i = '0; e_adc_q = '0; e_adc_valid = '0;
      e_rx = '0; e_tx = '0; e_rdy = '0; e_rssi_valid = '0; e_b = '0; e_avg = '0;
   endtask

   // Called right at a rising edge with the inputs the DUT sampled on that edge.
   task automatic model_step();
      logic edge_seen;
      edge_seen = bus.user_RSSI_ADC_clk && !m_strobe;
      e_rssi_valid = '0;
      for (int c = 0; c < NR; c++) begin
         int f;
         int req;
         bit in_rx, in_tx;
         f = NR - 1 - c;
         req = (bus.controller_RxEn[f] && !bus.controller_TxEn[f]) ? 1 :
               (bus.controller_TxEn[f] && !bus.controller_RxEn[f]) ? 2 : 0;
         in_rx = (m_gap[c] == 0) && (m_mode[c] == 1);
         in_tx = (m_gap[c] == 0) && (m_mode[c] == 2);
         e_rx[f] = in_rx; e_tx[f] = in_tx; e_rdy[f] = in_tx; e_adc_valid[f] = in_rx;
         e_dac_i[f*DW +: DW] = in_tx ? bus.user_DAC_I[f*DW +: DW] : '0;
         e_dac_q[f*DW +: DW] = in_tx ? bus.user_DAC_Q[f*DW +: DW] : '0;
         e_adc_i[f*AW +: AW] = in_rx ? m_adc_i[f*AW +: AW] : '0;
         e_adc_q[f*AW +: AW] = in_rx ? m_adc_q[f*AW +: AW] : '0;
         e_b[f*7 +: 7] = in_rx ? {bus.user_RxRF_gain[f*2 +: 2], bus.user_RxBB_gain[f*5 +: 5]} :
                         in_tx ? {1'b0, bus.user_Tx_gain[f*6 +: 6]} : 7'd0;
         if (m_gap[c] > 0) begin
            m_gap[c]--;
            if (m_gap[c] == 0) m_mode[c] = req;
         end else if (m_mode[c] == 0) begin
            m_mode[c] = req;
         end else if (req != m_mode[c]) begin
            m_gap[c] = TURN;
         end
         if (edge_seen) begin
            m_sum[c] += int'(bus.radio_RSSI_ADC_D[f*RW +: RW]);
            m_n[c]++;
            if (m_n[c] == (1 << AVGL)) begin
               e_avg[f*RW +: RW] = RW'(m_sum[c] / (1 << AVGL));
               e_rssi_valid[f] = 1'b1;
               m_sum[c] = 0; m_n[c] = 0;
            end
         end
      end
      m_adc_i = bus.radio_ADC_I;
      m_adc_q = bus.radio_ADC_Q;
      m_strobe = bus.user_RSSI_ADC_clk;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic set_req(input int c, input bit rx, input bit tx);
      bus.controller_RxEn[NR-1-c] = rx;
      bus.controller_TxEn[NR-1-c] = tx;
   endtask

   task automatic rand_data();
      bus.user_DAC_I = {NR{DW'($urandom)}} ^ (NR*DW)'({$urandom, $urandom});
      bus.user_DAC_Q = (NR*DW)'({$urandom, $urandom});
      bus.radio_ADC_I = (NR*AW)'({$urandom, $urandom});
      bus.radio_ADC_Q = (NR*AW)'({$urandom, $urandom});
      bus.user_Tx_gain = (NR*6)'($urandom);
      bus.user_RxRF_gain = (NR*2)'($urandom);
      bus.user_RxBB_gain = (NR*5)'($urandom);
      bus.radio_RSSI_ADC_D = (NR*RW)'($urandom);
   endtask

   task automatic init_inputs();
      bus.controller_RxEn = '0; bus.controller_TxEn = '0;
      bus.user_DAC_I = '0; bus.user_DAC_Q = '0; bus.radio_ADC_I = '0; bus.radio_ADC_Q = '0;
      bus.user_Tx_gain = '0; bus.user_RxRF_gain = '0; bus.user_RxBB_gain = '0;
      bus.user_RSSI_ADC_clk = 1'b0; bus.radio_RSSI_ADC_D = '0;
   endtask

   task automatic apply_reset();
      init_inputs();
      rst_n = 1'b0;
      #1;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      init_inputs();
      rst_n = 1'b0;
      model_reset();
      #2;
      checks++;
      if (obs_all !== '0) begin
         errors++; $display("FAIL reset_outputs: got %h expected 0", obs_all);
      end
      @(negedge clk);
      rst_n = 1'b1;
      set_req(0, 1'b0, 1'b1);
      bus.user_DAC_I[C0*DW +: DW] = 16'h7FFF;
      bus.user_Tx_gain[C0*6 +: 6] = 6'h2A;
      tick(); tick();
      checks++;
      if (bus.radio_DAC_I[C0*DW +: DW] !== 16'h7FFF || bus.radio_TxEn[C0] !== 1'b1) begin
         errors++;
         $display("FAIL tx_before_reset: got dac %h txen %b expected 7fff 1",
                  bus.radio_DAC_I[C0*DW +: DW], bus.radio_TxEn[C0]);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.radio_DAC_I, bus.radio_TxEn, bus.radio_B} !== '0) begin
         errors++;
         $display("FAIL reset_mid_tx: got dac %h txen %b b %h expected 0", bus.radio_DAC_I,
                  bus.radio_TxEn, bus.radio_B);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checks++;
      if (bus.radio_TxEn !== '0 || obs_all !== exp_all) begin
         errors++; $display("FAIL idle_after_release: got %h expected %h", obs_all, exp_all);
      end
      tick();
      checks++;
      if (bus.radio_TxEn[C0] !== 1'b1 || obs_all !== exp_all) begin
         errors++; $display("FAIL tx_after_release: got %h expected %h", obs_all, exp_all);
      end
   endtask

   task automatic test_rx();
      logic [6:0] gain;
      apply_reset();
      rand_data();
      bus.user_RSSI_ADC_clk = 1'b0;
      set_req(0, 1'b1, 1'b0);
      bus.radio_ADC_I[C0*AW +: AW] = 14'h1234;
      gain = {bus.user_RxRF_gain[C0*2 +: 2], bus.user_RxBB_gain[C0*5 +: 5]};
      tick();
      checks++;
      if (bus.radio_RxEn[C0] !== 1'b0) begin
         errors++; $display("FAIL rx_en_lag: got %b expected 0", bus.radio_RxEn[C0]);
      end
      tick();
      checks++;
      if (bus.radio_RxEn[C0] !== 1'b1) begin
         errors++; $display("FAIL rx_en: got %b expected 1", bus.radio_RxEn[C0]);
      end
      checks++;
      if (bus.user_ADC_I[C0*AW +: AW] !== 14'h1234 || bus.user_ADC_valid[C0] !== 1'b1) begin
         errors++;
         $display("FAIL adc_latency: got %h valid %b expected 1234 1",
                  bus.user_ADC_I[C0*AW +: AW], bus.user_ADC_valid[C0]);
      end
      checks++;
      if (bus.radio_B[C0*7 +: 7] !== gain) begin
         errors++; $display("FAIL rx_gain: got %h expected %h", bus.radio_B[C0*7 +: 7], gain);
      end
      bus.radio_ADC_I[C0*AW +: AW] = 14'h2BCD;
      tick();
      checks++;
      if (bus.user_ADC_I[C0*AW +: AW] !== 14'h1234) begin
         errors++; $display("FAIL adc_hold: got %h expected 1234", bus.user_ADC_I[C0*AW +: AW]);
      end
      tick();
      checks++;
      if (bus.user_ADC_I[C0*AW +: AW] !== 14'h2BCD) begin
         errors++; $display("FAIL adc_next: got %h expected 2bcd", bus.user_ADC_I[C0*AW +: AW]);
      end
      for (int i = 0; i < 20; i++) begin
         rand_data();
         tick();
         checks++;
         if (obs_all !== exp_all) begin
            errors++; $display("FAIL rx_model: got %h expected %h", obs_all, exp_all);
         end
      end
   endtask

   task automatic test_turnaround();
      int zero_cnt = 0;
      int first_tx = 0;
      apply_reset();
      set_req(0, 1'b1, 1'b0);
      tick(); tick(); tick();
      set_req(0, 1'b0, 1'b1);
      for (int i = 1; i <= int'(TURN) + 6; i++) begin
         rand_data();
         tick();
         checks++;
         if (obs_all !== exp_all) begin
            errors++; $display("FAIL turnaround_model: got %h expected %h", obs_all, exp_all);
         end
         if (bus.radio_RxEn[C0] === 1'b0 && bus.radio_TxEn[C0] === 1'b0) begin
            zero_cnt++;
            checks++;
            if (bus.radio_DAC_I[C0*DW +: DW] !== '0 || bus.radio_B[C0*7 +: 7] !== '0) begin
               errors++;
               $display("FAIL gap_forced_zero: got dac %h b %h expected 0",
                        bus.radio_DAC_I[C0*DW +: DW], bus.radio_B[C0*7 +: 7]);
            end
         end
         if (bus.radio_TxEn[C0] === 1'b1 && first_tx == 0) first_tx = i;
      end
      checks++;
      if (zero_cnt != int'(TURN)) begin
         errors++; $display("FAIL gap_length: got %0d expected %0d", zero_cnt, TURN);
      end
      checks++;
      if (first_tx != int'(TURN) + 2) begin
         errors++; $display("FAIL tx_start: got %0d expected %0d", first_tx, TURN + 2);
      end
   endtask

   task automatic test_conflict();
      int zero_cnt = 0;
      int back_on = 0;
      apply_reset();
      set_req(0, 1'b0, 1'b1);
      tick(); tick(); tick();
      for (int i = 1; i <= int'(TURN) + 6; i++) begin
         if (i == 1) set_req(0, 1'b1, 1'b1);
         else if (i <= int'(TURN)) set_req(0, (i % 2) == 0, 1'b1 ^ ((i % 2) == 0));
         else set_req(0, 1'b0, 1'b1);
         if (i > 2 && i <= int'(TURN) && (i % 3) == 0) set_req(0, 1'b1, 1'b1);
         rand_data();
         tick();
         checks++;
         if (obs_all !== exp_all) begin
            errors++; $display("FAIL conflict_model: got %h expected %h", obs_all, exp_all);
         end
         if (bus.radio_TxEn[C0] === 1'b0 && bus.radio_RxEn[C0] === 1'b0 && back_on == 0)
            zero_cnt++;
         if (bus.radio_TxEn[C0] === 1'b1 && zero_cnt > 0 && back_on == 0) back_on = i;
      end
      checks++;
      if (zero_cnt != int'(TURN) || back_on != int'(TURN) + 2) begin
         errors++;
         $display("FAIL gap_not_extended: got %0d zero cycles, tx back at %0d expected %0d %0d",
                  zero_cnt, back_on, TURN, TURN + 2);
      end
      set_req(0, 1'b1, 1'b1);
      for (int i = 0; i < int'(TURN) + 4; i++) begin
         rand_data();
         tick();
         checks++;
         if (obs_all !== exp_all) begin
            errors++; $display("FAIL conflict_idle_model: got %h expected %h", obs_all, exp_all);
         end
      end
      checks++;
      if (obs_all !== '0) begin
         errors++; $display("FAIL conflict_all_zero: got %h expected 0", obs_all);
      end
   endtask

   task automatic test_rssi();
      int s0[4] = '{100, 101, 102, 103};
      int s1[4] = '{10, 20, 30, 41};
      int hold[4] = '{5, 1, 2, 1};
      int pulses = 0;
      apply_reset();
      for (int k = 0; k < 4; k++) begin
         bus.radio_RSSI_ADC_D[C0*RW +: RW] = RW'(s0[k]);
         bus.radio_RSSI_ADC_D[(C0-1)*RW +: RW] = RW'(s1[k]);
         bus.user_RSSI_ADC_clk = 1'b1;
         for (int h = 0; h < hold[k] + 2; h++) begin
            if (h == hold[k]) bus.user_RSSI_ADC_clk = 1'b0;
            tick();
            checks++;
            if (obs_all !== exp_all) begin
               errors++; $display("FAIL rssi_model: got %h expected %h", obs_all, exp_all);
            end
            if (bus.user_RSSI_valid[C0] === 1'b1) pulses++;
         end
      end
      checks++;
      if (pulses != 1) begin
         errors++; $display("FAIL rssi_pulses: got %0d expected 1", pulses);
      end
      checks++;
      if (bus.user_RSSI_avg[C0*RW +: RW] !== 10'd101) begin
         errors++; $display("FAIL rssi_avg0: got %0d expected 101", bus.user_RSSI_avg[C0*RW +: RW]);
      end
      checks++;
      if (bus.user_RSSI_avg[(C0-1)*RW +: RW] !== 10'd25) begin
         errors++;
         $display("FAIL rssi_avg1: got %0d expected 25", bus.user_RSSI_avg[(C0-1)*RW +: RW]);
      end
   endtask

   task automatic test_two_channels();
      apply_reset();
      set_req(0, 1'b0, 1'b1);
      set_req(1, 1'b1, 1'b0);
      rand_data();
      tick(); tick();
      for (int i = 0; i < 20; i++) begin
         rand_data();
         tick();
         checks++;
         if (obs_all !== exp_all) begin
            errors++; $display("FAIL two_chan_model: got %h expected %h", obs_all, exp_all);
         end
         checks++;
         if (bus.radio_TxEn !== 2'b10 || bus.radio_RxEn !== 2'b01 ||
             bus.radio_DAC_I[(C0-1)*DW +: DW] !== '0 || bus.user_ADC_I[C0*AW +: AW] !== '0) begin
            errors++;
            $display("FAIL two_chan_isolation: got tx %b rx %b dac1 %h adc0 %h expected 10 01 0 0",
                     bus.radio_TxEn, bus.radio_RxEn, bus.radio_DAC_I[(C0-1)*DW +: DW],
                     bus.user_ADC_I[C0*AW +: AW]);
         end
      end
   endtask

   task automatic test_random();
      apply_reset();
      for (int i = 0; i < 600; i++) begin
         for (int c = 0; c < NR; c++) begin
            if ($urandom_range(0, 5) == 0)
               set_req(c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end
         if ($urandom_range(0, 2) == 0) bus.user_RSSI_ADC_clk = ~bus.user_RSSI_ADC_clk;
         rand_data();
         tick();
         checks++;
         if (obs_all !== exp_all) begin
            errors++; $display("FAIL random_model: cycle %0d got %h expected %h", i, obs_all,
                               exp_all);
         end
      end
   endtask

   initial begin
      test_reset();
      test_rx();
      test_turnaround();
      test_conflict();
      test_rssi();
      test_two_channels();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
